intc_one_sel: RTL and testbench
===============================

Name: intc_one_sel

Overview:
- Interrupt selector/scheduler that feeds the single-CPU interrupt interface (cpuif).
- Captures pending state for REG_NUM*32 normal sources plus NMI and bus-error, and arbitrates by per-source level and the CPU mask.
- Presents the winner as sl_req/sl_level/sl_vec, and clears the acked source from the cpuif one-hot acks.
- Sequences the ack-clear handshake by pulsing sync_cpu_int_o, which lets cpuif drop cp_intack_all.

Parameters:
- REG_NUM, 1: number of 32-source groups; N = REG_NUM*32 normal interrupts, vectors 64..64+N-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- irq_i  in  N  normal interrupt lines; rising edge sets pending
- nmi_i  in  1  NMI line; rising edge sets pending
- err_i  in  1  bus-error line; rising edge sets pending
- cfg_level_i  in  4*N  per-source level, source n at [4n+3:4n]; 0 = disabled
- cpu_imask_i  in  4  CPU interrupt mask level
- sl_req_o  out  1  request to cpuif
- sl_level_o  out  5  winner level
- sl_vec_o  out  8  winner vector
- cp_intack_nmi_i  in  1  NMI acked (from cpuif)
- cp_intack_err_i  in  1  error acked
- cp_intack_i  in  N  one-hot normal ack
- cp_intack_all_i  in  1  ack-in-progress flag from cpuif
- sync_cpu_int_o  out  1  one-cycle pulse: pending cleared, cpuif may drop cp_intack_all
- pend_o  out  N  normal pending bits (status)

Behaviour:
- Reset (rst_n=0, async): all outputs 0, pending/NMI/err pending 0, edge-detect registers 0, rr_ptr 0, FSM IDLE. Asserting mid-handshake aborts the handshake; no pulse is issued.
- Edge detect uses registered copies of irq_i/nmi_i/err_i. A pending bit sets in the cycle after a rising edge is sampled.
- Pending clear: a pending bit clears when its cp_intack bit is 1 in the REQ-state ack cycle. If a new edge coincides with the clear, set wins.
- Eligibility:
  - normal n: pend[n] & level_n != 0 & level_n > cpu_imask_i.
  - NMI and error: eligible whenever pending; mask is ignored.
- Priority:
  - error (level 16, vec 9) > NMI (level 16, vec 11) > normal.
  - Among normals, highest level wins (5-bit level = {1'b0, level_n}, vec = 64+n).
  - Equal levels: round-robin, search starts at rr_ptr and wraps from N-1 to 0.
  - rr_ptr becomes acked index+1, mod N, on a normal ack.
- FSM:
  - IDLE: if any source is eligible, register the winner into sl_level_o/sl_vec_o, set sl_req_o=1, go REQ. Latency is 2 cycles from the sampled edge to sl_req_o.
  - REQ: re-arbitrate and re-register every cycle. A higher level preempts; the vector may change before ack. If nothing is eligible (disabled or masked), sl_req_o<=0 and go IDLE.
  - REQ with cp_intack_all_i=1: sl_req_o<=0, clear the acked pending per the cp_intack_* one-hot (independent of the current winner), go SYNC.
  - SYNC: sync_cpu_int_o=1 for exactly one cycle, go WAIT.
  - WAIT: hold sl_req_o=0 until cp_intack_all_i=0, then go IDLE. New pends still accumulate in this state.
- The ack path clears by one-hot only. A zero or multi-hot ack clears whatever bits are set; no error is raised.
- sl_level_o/sl_vec_o hold their last value when sl_req_o=0.

Test Plan:
- Single source: N=32, cfg_level src5=7, imask 0, edge on irq_i[5] -> sl_req_o=1 two cycles later, level 7, vec 69. Drive cp_intack_i[5] with cp_intack_all_i=1 -> pend[5]=0, sync_cpu_int_o pulses once, FSM returns to IDLE after cp_intack_all_i falls.
- Priority and mask:
  - src3 level 4 and src10 level 9 pending, imask 5 -> vec 74, level 9.
  - After src10 is acked -> no request (4 ≤ 5).
  - imask set to 3 -> vec 67.
- Round-robin: src2 and src20 pending, both level 6, rr_ptr 0 -> vec 66 first. After ack, rr_ptr=3 -> vec 84 next; re-pend src2 during this and verify vec 84 is still chosen.
- Preemption and NMI/error:
  - In REQ with vec 70, an NMI edge -> sl_vec_o=11, level 16.
  - err and NMI pending together -> vec 9 first, NMI next.
- Simultaneous set/clear and reset: irq_i[1] edge in the same cycle as its ack -> pend[1] stays 1 and is re-requested. rst_n low during SYNC -> all outputs 0 at once, no sync pulse.

Source files
------------

// File: rtl/intc_one_sel.sv
// Interrupt selector for the single-CPU interface: captures source edges, arbitrates by level
// with round-robin tie-break, and sequences the cpuif ack-clear handshake.
module intc_one_sel #(
   parameter int unsigned REG_NUM = 1,
   localparam int unsigned N = REG_NUM * 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   irq_i,
   input  logic           nmi_i,
   input  logic           err_i,
   input  logic [4*N-1:0] cfg_level_i,
   input  logic [3:0]     cpu_imask_i,
   output logic           sl_req_o,
   output logic [4:0]     sl_level_o,
   output logic [7:0]     sl_vec_o,
   input  logic           cp_intack_nmi_i,
   input  logic           cp_intack_err_i,
   input  logic [N-1:0]   cp_intack_i,
   input  logic           cp_intack_all_i,
   output logic           sync_cpu_int_o,
   output logic [N-1:0]   pend_o
);
   localparam int unsigned IdxW = $clog2(N);

   typedef enum logic [1:0] {StIdle, StReq, StSync, StWait} state_e;

   state_e          r_state, w_state_d;
   logic [N-1:0]    r_irq_prev, r_pend, w_pend_d;
   logic            r_nmi_prev, r_err_prev, r_nmi_pend, r_err_pend;
   logic            w_nmi_pend_d, w_err_pend_d;
   logic [IdxW-1:0] r_rr_ptr, w_rr_ptr_d;
   logic            r_req, w_req_d;
   logic [4:0]      r_level, w_level_d;
   logic [7:0]      r_vec, w_vec_d;
   logic            w_ack;
   logic            w_norm_found;
   logic [3:0]      w_norm_level;
   logic [IdxW-1:0] w_norm_idx;
   logic            w_win_found;
   logic [4:0]      w_win_level;
   logic [7:0]      w_win_vec;

   assign w_ack = (r_state == StReq) && cp_intack_all_i;

   // A fresh edge wins over a clear landing in the same cycle
   assign w_pend_d     = (r_pend & ~(cp_intack_i & {N{w_ack}})) | (irq_i & ~r_irq_prev);
   assign w_nmi_pend_d = (r_nmi_pend & ~(cp_intack_nmi_i & w_ack)) | (nmi_i & ~r_nmi_prev);
   assign w_err_pend_d = (r_err_pend & ~(cp_intack_err_i & w_ack)) | (err_i & ~r_err_prev);

   // Scan starts at rr_ptr; strict '>' keeps the first hit in round-robin order on equal levels
   always_comb begin
      logic [IdxW:0]   idx_sum;
      logic [IdxW-1:0] idx;
      logic [3:0]      lv;
      w_norm_found = 1'b0;
      w_norm_level = '0;
      w_norm_idx   = '0;
      idx_sum      = '0;
      idx          = '0;
      lv           = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx_sum = {1'b0, r_rr_ptr} + (IdxW+1)'(i);
         if (idx_sum >= (IdxW+1)'(N)) idx_sum = idx_sum - (IdxW+1)'(N);
         idx = idx_sum[IdxW-1:0];
         lv  = cfg_level_i[{idx, 2'b00} +: 4];
         if (r_pend[idx] && (lv != 4'd0) && (lv > cpu_imask_i) && (lv > w_norm_level)) begin
            w_norm_found = 1'b1;
            w_norm_level = lv;
            w_norm_idx   = idx;
         end
      end
   end

   always_comb begin
      w_win_found = 1'b1;
      w_win_level = 5'd16;
      w_win_vec   = 8'd9;
      if (r_err_pend) begin
         w_win_vec = 8'd9;
      end else if (r_nmi_pend) begin
         w_win_vec = 8'd11;
      end else if (w_norm_found) begin
         w_win_level = {1'b0, w_norm_level};
         w_win_vec   = 8'd64 + 8'(w_norm_idx);
      end else begin
         w_win_found = 1'b0;
      end
   end

   always_comb begin
      w_rr_ptr_d = r_rr_ptr;
      if (w_ack) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (cp_intack_i[i]) w_rr_ptr_d = (i == N - 1) ? '0 : IdxW'(i + 1);
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_req_d   = r_req;
      w_level_d = r_level;
      w_vec_d   = r_vec;
      unique case (r_state)
         StIdle: begin
            if (w_win_found) begin
               w_req_d   = 1'b1;
               w_level_d = w_win_level;
               w_vec_d   = w_win_vec;
               w_state_d = StReq;
            end
         end
         StReq: begin
            if (cp_intack_all_i) begin
               w_req_d   = 1'b0;
               w_state_d = StSync;
            end else if (w_win_found) begin
               w_level_d = w_win_level;
               w_vec_d   = w_win_vec;
            end else begin
               w_req_d   = 1'b0;
               w_state_d = StIdle;
            end
         end
         StSync: w_state_d = StWait;
         StWait: begin
            if (!cp_intack_all_i) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_irq_prev <= '0;
         r_nmi_prev <= 1'b0;
         r_err_prev <= 1'b0;
         r_pend     <= '0;
         r_nmi_pend <= 1'b0;
         r_err_pend <= 1'b0;
         r_rr_ptr   <= '0;
         r_req      <= 1'b0;
         r_level    <= '0;
         r_vec      <= '0;
      end else begin
         r_state    <= w_state_d;
         r_irq_prev <= irq_i;
         r_nmi_prev <= nmi_i;
         r_err_prev <= err_i;
         r_pend     <= w_pend_d;
         r_nmi_pend <= w_nmi_pend_d;
         r_err_pend <= w_err_pend_d;
         r_rr_ptr   <= w_rr_ptr_d;
         r_req      <= w_req_d;
         r_level    <= w_level_d;
         r_vec      <= w_vec_d;
      end
   end

   assign sl_req_o       = r_req;
   assign sl_level_o     = r_level;
   assign sl_vec_o       = r_vec;
   assign sync_cpu_int_o = (r_state == StSync);
   assign pend_o         = r_pend;

endmodule

// File: tb/tb_intc_one_sel.sv
// Bench for intc_one_sel: directed vectors, a per-cycle reference model compare,
// and literal spot checks that pin the model.
module tb_intc_one_sel;
   localparam int N = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   irq_i = '0;
   logic           nmi_i = 1'b0;
   logic           err_i = 1'b0;
   logic [4*N-1:0] cfg_level_i = '0;
   logic [3:0]     cpu_imask_i = '0;
   logic           sl_req_o;
   logic [4:0]     sl_level_o;
   logic [7:0]     sl_vec_o;
   logic           cp_intack_nmi_i = 1'b0;
   logic           cp_intack_err_i = 1'b0;
   logic [N-1:0]   cp_intack_i = '0;
   logic           cp_intack_all_i = 1'b0;
   logic           sync_cpu_int_o;
   logic [N-1:0]   pend_o;

   intc_one_sel #(.REG_NUM(1)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .irq_i           (irq_i),
      .nmi_i           (nmi_i),
      .err_i           (err_i),
      .cfg_level_i     (cfg_level_i),
      .cpu_imask_i     (cpu_imask_i),
      .sl_req_o        (sl_req_o),
      .sl_level_o      (sl_level_o),
      .sl_vec_o        (sl_vec_o),
      .cp_intack_nmi_i (cp_intack_nmi_i),
      .cp_intack_err_i (cp_intack_err_i),
      .cp_intack_i     (cp_intack_i),
      .cp_intack_all_i (cp_intack_all_i),
      .sync_cpu_int_o  (sync_cpu_int_o),
      .pend_o          (pend_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit running = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending sets plus a handshake stage
   // (0 idle, 1 requesting, 2 sync pulse, 3 waiting for ack_all to fall)
   logic [N-1:0] m_pend, m_prev;
   logic         m_nmi, m_err, m_nmi_prev, m_err_prev;
   int unsigned  m_rr;
   int           m_stage;
   logic         m_req;
   logic [4:0]   m_lvl;
   logic [7:0]   m_vec;
   logic [13:0]  m_win;
   logic         m_ack;

   // Winner = {found, level, vector}; ties go to the smallest forward distance from rr
   function automatic logic [13:0] pick(input logic [N-1:0] p, input logic nm, input logic er,
                                        input int unsigned rr, input logic [4*N-1:0] cfg,
                                        input logic [3:0] mask);
      int best_lvl = 0;
      int best_n = -1;
      int best_d = N;
      if (er) return {1'b1, 5'd16, 8'd9};
      if (nm) return {1'b1, 5'd16, 8'd11};
      for (int n = 0; n < N; n++) begin
         int lv = int'(cfg[4*n +: 4]);
         int d = (n - int'(rr) + N) % N;
         if (p[n] && lv > 0 && lv > int'(mask) &&
             (lv > best_lvl || (lv == best_lvl && d < best_d))) begin
            best_lvl = lv;
            best_n = n;
            best_d = d;
         end
      end
      if (best_n < 0) return '0;
      return {1'b1, 5'(best_lvl), 8'(64 + best_n)};
   endfunction

   function automatic int unsigned rr_next(input logic [N-1:0] ack, input int unsigned cur);
      int unsigned r = cur;
      for (int n = 0; n < N; n++) if (ack[n]) r = (n + 1) % N;
      return r;
   endfunction

   always_comb m_win = pick(m_pend, m_nmi, m_err, m_rr, cfg_level_i, cpu_imask_i);
   assign m_ack = (m_stage == 1) && cp_intack_all_i;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend <= '0; m_prev <= '0;
         m_nmi <= 1'b0; m_err <= 1'b0; m_nmi_prev <= 1'b0; m_err_prev <= 1'b0;
         m_rr <= 0; m_stage <= 0; m_req <= 1'b0; m_lvl <= '0; m_vec <= '0;
      end else begin
         m_prev <= irq_i;
         m_nmi_prev <= nmi_i;
         m_err_prev <= err_i;
         for (int n = 0; n < N; n++)
            m_pend[n] <= (irq_i[n] && !m_prev[n]) ? 1'b1 :
                         (m_ack && cp_intack_i[n]) ? 1'b0 : m_pend[n];
         m_nmi <= (nmi_i && !m_nmi_prev) ? 1'b1 : (m_ack && cp_intack_nmi_i) ? 1'b0 : m_nmi;
         m_err <= (err_i && !m_err_prev) ? 1'b1 : (m_ack && cp_intack_err_i) ? 1'b0 : m_err;
         case (m_stage)
            0: if (m_win[13]) begin
                  m_req <= 1'b1; m_lvl <= m_win[12:8]; m_vec <= m_win[7:0]; m_stage <= 1;
               end
            1: if (cp_intack_all_i) begin
                  m_req <= 1'b0; m_rr <= rr_next(cp_intack_i, m_rr); m_stage <= 2;
               end else if (m_win[13]) begin
                  m_lvl <= m_win[12:8]; m_vec <= m_win[7:0];
               end else begin
                  m_req <= 1'b0; m_stage <= 0;
               end
            2: m_stage <= 3;
            default: if (!cp_intack_all_i) m_stage <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (running) begin
         chk("model req", 32'(sl_req_o), 32'(m_req));
         chk("model level", 32'(sl_level_o), 32'(m_lvl));
         chk("model vec", 32'(sl_vec_o), 32'(m_vec));
         chk("model sync", 32'(sync_cpu_int_o), 32'(m_stage == 2));
         chk("model pend", pend_o, m_pend);
      end
   end

   task automatic step(input int k = 1);
      repeat (k) @(negedge clk);
   endtask

   task automatic set_lvl(input int n, input int l);
      cfg_level_i[4*n +: 4] = 4'(l);
   endtask

   task automatic do_reset();
      irq_i = '0; nmi_i = 1'b0; err_i = 1'b0; cfg_level_i = '0; cpu_imask_i = '0;
      cp_intack_i = '0; cp_intack_nmi_i = 1'b0; cp_intack_err_i = 1'b0; cp_intack_all_i = 1'b0;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   // Ack cycle, then sync, then drop ack_all; returns with the DUT back in idle
   task automatic ack(input logic [N-1:0] one, input logic nm, input logic er);
      cp_intack_i = one; cp_intack_nmi_i = nm; cp_intack_err_i = er; cp_intack_all_i = 1'b1;
      step(1);
      cp_intack_i = '0; cp_intack_nmi_i = 1'b0; cp_intack_err_i = 1'b0;
      step(1);
      cp_intack_all_i = 1'b0;
      step(1);
   endtask

   initial begin
      do_reset();
      running = 1'b1;
      chk("reset req", 32'(sl_req_o), 0);
      chk("reset vec", 32'(sl_vec_o), 0);
      chk("reset sync", 32'(sync_cpu_int_o), 0);
      chk("reset pend", pend_o, 0);

      // Single source, full handshake
      set_lvl(5, 7);
      irq_i[5] = 1'b1;
      step(1);
      chk("t1 pend5 set", 32'(pend_o[5]), 1);
      chk("t1 req not yet", 32'(sl_req_o), 0);
      step(1);
      chk("t1 req", 32'(sl_req_o), 1);
      chk("t1 level", 32'(sl_level_o), 7);
      chk("t1 vec", 32'(sl_vec_o), 69);
      cp_intack_i = 32'h20; cp_intack_all_i = 1'b1;
      step(1);
      chk("t1 pend5 clr", 32'(pend_o[5]), 0);
      chk("t1 sync pulse", 32'(sync_cpu_int_o), 1);
      chk("t1 req drop", 32'(sl_req_o), 0);
      cp_intack_i = '0;
      step(1);
      chk("t1 sync once", 32'(sync_cpu_int_o), 0);
      step(1);
      chk("t1 wait hold", 32'(sl_req_o), 0);
      cp_intack_all_i = 1'b0;
      step(2);
      chk("t1 idle", 32'(sl_req_o), 0);
      chk("t1 held vec", 32'(sl_vec_o), 69);

      // Priority and mask
      do_reset();
      set_lvl(3, 4); set_lvl(10, 9); cpu_imask_i = 4'd5;
      irq_i[3] = 1'b1; irq_i[10] = 1'b1;
      step(2);
      chk("t2 vec", 32'(sl_vec_o), 74);
      chk("t2 level", 32'(sl_level_o), 9);
      ack(32'h400, 1'b0, 1'b0);
      step(2);
      chk("t2 masked", 32'(sl_req_o), 0);
      chk("t2 pend3", pend_o, 32'h8);
      cpu_imask_i = 4'd3;
      step(1);
      chk("t2 unmask req", 32'(sl_req_o), 1);
      chk("t2 unmask vec", 32'(sl_vec_o), 67);

      // Round-robin with re-pend of src2 during its own ack
      do_reset();
      set_lvl(2, 6); set_lvl(20, 6);
      irq_i[2] = 1'b1; irq_i[20] = 1'b1;
      step(2);
      chk("t3 first vec", 32'(sl_vec_o), 66);
      irq_i[2] = 1'b0;
      step(1);
      irq_i[2] = 1'b1;
      ack(32'h4, 1'b0, 1'b0);
      step(1);
      chk("t3 rr vec", 32'(sl_vec_o), 84);
      chk("t3 src2 repend", 32'(pend_o[2]), 1);
      ack(32'h100000, 1'b0, 1'b0);
      step(1);
      chk("t3 wrap vec", 32'(sl_vec_o), 66);

      // Preemption by NMI, error above NMI
      do_reset();
      set_lvl(6, 5);
      irq_i[6] = 1'b1;
      step(2);
      chk("t4 vec70", 32'(sl_vec_o), 70);
      nmi_i = 1'b1;
      step(2);
      chk("t4 nmi vec", 32'(sl_vec_o), 11);
      chk("t4 nmi level", 32'(sl_level_o), 16);
      err_i = 1'b1;
      step(2);
      chk("t4 err vec", 32'(sl_vec_o), 9);
      ack('0, 1'b0, 1'b1);
      step(1);
      chk("t4 nmi next", 32'(sl_vec_o), 11);
      ack('0, 1'b1, 1'b0);
      step(1);
      chk("t4 back to 70", 32'(sl_vec_o), 70);
      chk("t4 level 5", 32'(sl_level_o), 5);

      // Set coinciding with clear, then reset during the sync cycle
      do_reset();
      set_lvl(1, 3);
      irq_i[1] = 1'b1;
      step(2);
      chk("t5 vec", 32'(sl_vec_o), 65);
      irq_i[1] = 1'b0;
      step(1);
      irq_i[1] = 1'b1; cp_intack_i = 32'h2; cp_intack_all_i = 1'b1;
      step(1);
      chk("t5 set wins", 32'(pend_o[1]), 1);
      cp_intack_i = '0;
      step(1);
      cp_intack_all_i = 1'b0;
      step(2);
      chk("t5 rereq", 32'(sl_req_o), 1);
      chk("t5 rereq vec", 32'(sl_vec_o), 65);
      cp_intack_i = 32'h2; cp_intack_all_i = 1'b1;
      step(1);
      chk("t5 in sync", 32'(sync_cpu_int_o), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5 rst sync", 32'(sync_cpu_int_o), 0);
      chk("t5 rst req", 32'(sl_req_o), 0);
      chk("t5 rst vec", 32'(sl_vec_o), 0);
      chk("t5 rst pend", pend_o, 0);
      irq_i = '0; cp_intack_i = '0; cp_intack_all_i = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(3);
      chk("t5 no pulse", 32'(sync_cpu_int_o), 0);
      chk("t5 idle after rst", 32'(sl_req_o), 0);

      running = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
